// File: rtl/ele_motion_ctrl.sv
// Elevator run controller: sequences floor travel, door dwell and direction
// reversal for a 4-storey car, driven by the registered request vector.
module ele_motion_ctrl #(
    parameter int MOVE_TICKS = 64,
    parameter int DOOR_TICKS = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] allReq,
    input  logic       up_need,
    input  logic       down_need,
    output logic [3:0] position,
    output logic [1:0] ud_mode,
    output logic [1:0] floor_num,
    output logic       door_open,
    output logic       moving
);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

    localparam logic [7:0] MOVE_LAST = 8'(MOVE_TICKS - 1);
    localparam logic [7:0] DOOR_LAST = 8'(DOOR_TICKS - 1);

    state_t     state_q, state_d;
    logic [3:0] pos_q, pos_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_up_q, dir_up_d;
    logic [1:0] ud_q, ud_d;
    logic [1:0] floor_q, floor_d;
    logic       door_q, door_d;
    logic       moving_q, moving_d;
    logic       here, above, below;

    function automatic logic req_above(input logic [3:0] req, input logic [3:0] pos);
        logic [3:0] mask;
        mask = 4'(pos << 1) - 4'd1;
        return |(req & ~mask);
    endfunction

    function automatic logic req_below(input logic [3:0] req, input logic [3:0] pos);
        return |(req & (pos - 4'd1));
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] pos);
        case (pos)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign here  = |(allReq & pos_q);
    assign above = req_above(allReq, pos_q);
    assign below = req_below(allReq, pos_q);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (here) begin
                    state_d = DOOR;
                end else if (up_need && above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (down_need && below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP: begin
                if (pos_q[3]) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == MOVE_LAST) begin
                    // Arrival is judged at the new floor against the live requests.
                    pos_d = pos_q << 1;
                    cnt_d = 8'd0;
                    if (|(allReq & pos_d))
                        state_d = DOOR;
                    else if (pos_d[3] || !req_above(allReq, pos_d))
                        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MOVE_DOWN: begin
                if (pos_q[0]) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == MOVE_LAST) begin
                    pos_d = pos_q >> 1;
                    cnt_d = 8'd0;
                    if (|(allReq & pos_d))
                        state_d = DOOR;
                    else if (pos_d[0] || !req_below(allReq, pos_d))
                        state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DOOR: begin
                if (here) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == DOOR_LAST) begin
                    // Keep going the way we came; reverse only when that side is empty.
                    cnt_d = 8'd0;
                    if (above && (dir_up_q || !below)) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                    end else if (below) begin
                        state_d  = MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        ud_d     = 2'b00;
        door_d   = 1'b0;
        moving_d = 1'b0;
        floor_d  = encode(pos_d);
        unique case (state_d)
            MOVE_UP: begin
                ud_d     = 2'b01;
                moving_d = 1'b1;
            end
            MOVE_DOWN: begin
                ud_d     = 2'b10;
                moving_d = 1'b1;
            end
            DOOR: begin
                door_d = 1'b1;
                if (dir_up_d)
                    ud_d = req_above(allReq, pos_d) ? 2'b01 : 2'b00;
                else
                    ud_d = req_below(allReq, pos_d) ? 2'b10 : 2'b00;
            end
            IDLE: ud_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pos_q    <= 4'b0001;
            cnt_q    <= 8'd0;
            dir_up_q <= 1'b1;
            ud_q     <= 2'b00;
            floor_q  <= 2'd0;
            door_q   <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            ud_q     <= ud_d;
            floor_q  <= floor_d;
            door_q   <= door_d;
            moving_q <= moving_d;
        end
    end

    assign position  = pos_q;
    assign ud_mode   = ud_q;
    assign floor_num = floor_q;
    assign door_open = door_q;
    assign moving    = moving_q;

endmodule

// File: tb/tb_ele_motion_ctrl.sv
// Scoreboard bench for ele_motion_ctrl: a floor-indexed reference model
// predicts each cycle's outputs, which are queued and compared after the edge.
module tb_ele_motion_ctrl;

    localparam int MT = 4;
    localparam int DT = 6;

    logic       clk;
    logic       rst_n;
    logic [3:0] allReq;
    logic       up_need;
    logic       down_need;
    logic [3:0] position;
    logic [1:0] ud_mode;
    logic [1:0] floor_num;
    logic       door_open;
    logic       moving;

    ele_motion_ctrl #(.MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .allReq    (allReq),
        .up_need   (up_need),
        .down_need (down_need),
        .position  (position),
        .ud_mode   (ud_mode),
        .floor_num (floor_num),
        .door_open (door_open),
        .moving    (moving)
    );

    typedef struct packed {
        logic [3:0] pos;
        logic [1:0] ud;
        logic [1:0] fl;
        logic       door;
        logic       mv;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference model state: 0 idle, 1 up, 2 down, 3 door
    int   m_state, m_floor, m_cnt;
    bit   m_up;
    logic [1:0] m_ud;
    bit   m_door, m_mv;

    logic [3:0] req;
    bit         force_up;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit has_above(input int f, input logic [3:0] r);
        for (int i = f + 1; i < 4; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit has_below(input int f, input logic [3:0] r);
        for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_floor = 0; m_cnt = 0; m_up = 1'b1;
        m_ud = 2'b00; m_door = 1'b0; m_mv = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input bit un, input bit dn);
        case (m_state)
            0: begin
                if (r[m_floor]) m_state = 3;
                else if (un && has_above(m_floor, r)) begin m_state = 1; m_up = 1'b1; end
                else if (dn && has_below(m_floor, r)) begin m_state = 2; m_up = 1'b0; end
                m_cnt = 0;
            end
            1: begin
                if (m_floor == 3) begin m_state = 0; m_cnt = 0; end
                else if (m_cnt == MT - 1) begin
                    m_floor++; m_cnt = 0;
                    if (r[m_floor]) m_state = 3;
                    else if (m_floor == 3 || !has_above(m_floor, r)) m_state = 0;
                end else m_cnt++;
            end
            2: begin
                if (m_floor == 0) begin m_state = 0; m_cnt = 0; end
                else if (m_cnt == MT - 1) begin
                    m_floor--; m_cnt = 0;
                    if (r[m_floor]) m_state = 3;
                    else if (m_floor == 0 || !has_below(m_floor, r)) m_state = 0;
                end else m_cnt++;
            end
            default: begin
                if (r[m_floor]) m_cnt = 0;
                else if (m_cnt == DT - 1) begin
                    m_cnt = 0;
                    if (m_up && has_above(m_floor, r)) m_state = 1;
                    else if (!m_up && has_below(m_floor, r)) m_state = 2;
                    else if (has_above(m_floor, r)) begin m_state = 1; m_up = 1'b1; end
                    else if (has_below(m_floor, r)) begin m_state = 2; m_up = 1'b0; end
                    else m_state = 0;
                end else m_cnt++;
            end
        endcase
        m_door = (m_state == 3);
        m_mv   = (m_state == 1) || (m_state == 2);
        case (m_state)
            1: m_ud = 2'b01;
            2: m_ud = 2'b10;
            3: m_ud = m_up ? (has_above(m_floor, r) ? 2'b01 : 2'b00)
                           : (has_below(m_floor, r) ? 2'b10 : 2'b00);
            default: m_ud = 2'b00;
        endcase
    endtask

    task automatic step();
        exp_t e, got;
        allReq    = req;
        up_need   = force_up | has_above(m_floor, req);
        down_need = has_below(m_floor, req);
        model_step(req, up_need, down_need);
        e.pos  = 4'b0001 << m_floor;
        e.ud   = m_ud;
        e.fl   = 2'(m_floor);
        e.door = m_door;
        e.mv   = m_mv;
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("position", 32'(position), 32'(got.pos));
        chk("ud_mode", 32'(ud_mode), 32'(got.ud));
        chk("floor_num", 32'(floor_num), 32'(got.fl));
        chk("door_open", 32'(door_open), 32'(got.door));
        chk("moving", 32'(moving), 32'(got.mv));
        chk("pos_onehot", 32'($onehot(position)), 32'd1);
        chk("ud_legal", 32'(ud_mode != 2'b11), 32'd1);
        // the request stage clears a call once the door opens at that floor
        if (m_door) req[m_floor] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        #2;
        req = 4'b0000; force_up = 1'b0;
        allReq = 4'b0000; up_need = 1'b0; down_need = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_position", 32'(position), 32'h1);
        chk("rst_ud_mode", 32'(ud_mode), 32'h0);
        chk("rst_door_open", 32'(door_open), 32'h0);
        chk("rst_floor_num", 32'(floor_num), 32'h0);
        chk("rst_moving", 32'(moving), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b1;
        req = 4'b0000; force_up = 1'b0;
        allReq = 4'b0000; up_need = 1'b0; down_need = 1'b0;
        model_reset();
        do_reset();

        // travel toward floor 4, then reset asynchronously while moving past floor 2
        req = 4'b1000;
        run(6);
        chk("premove_floor2", 32'(position), 32'h2);
        do_reset();

        // single up call to floor 3, dwell, back to idle
        req = 4'b0100;
        run(20);

        // door at floor 3 with last direction up, then a call at floor 1 reverses
        req = 4'b0100;
        run(2);
        req = 4'b0001;
        run(25);

        // call at the current floor, re-opened during the dwell
        req = 4'b0001;
        run(5);
        req = 4'b0001;
        run(15);

        // stop at floor 2 going up, then calls at 1 and 4: continue up first
        req = 4'b0010;
        run(7);
        req = 4'b1001;
        run(60);

        // top limit: sit at floor 4 with upward demand but nothing above
        req = 4'b1000;
        run(25);
        force_up = 1'b1;
        req = 4'b0000;
        run(10);
        force_up = 1'b0;

        // random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7) == 0) req[$urandom_range(3)] = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
